// File: rtl/hack_exec_stage.sv
// Hack CPU execute/control stage: holds A/D, drives the external ALU,
// sequences data-memory read/write and retires each instruction with a new PC.
module hack_exec_stage #(
    parameter int                PC_W     = 15,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic [PC_W-1:0] pc_out,
    output logic            pc_valid,
    output logic [15:0]     a_reg,
    output logic [15:0]     d_reg,
    output logic [15:0]     alu_x,
    output logic [15:0]     alu_y,
    output logic            alu_zx,
    output logic            alu_nx,
    output logic            alu_zy,
    output logic            alu_ny,
    output logic            alu_f,
    output logic            alu_no,
    input  logic [15:0]     alu_out,
    input  logic            alu_zr,
    input  logic            alu_ng,
    output logic [PC_W-1:0] mem_addr,
    output logic            mem_rd,
    input  logic [15:0]     mem_rdata,
    input  logic            mem_rvalid,
    output logic            mem_wr,
    output logic [15:0]     mem_wdata,
    input  logic            mem_wack
);

    typedef enum logic [1:0] {IDLE, MREAD, EXEC, MWRITE} state_t;

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_t          state;
    logic [12:0]     ir;
    logic [15:0]     m_lat;
    logic [PC_W-1:0] addr_lat;
    logic [PC_W-1:0] pc_lat;
    logic            in_exec;
    logic            jump;
    logic            unused_bits;

    assign unused_bits = ^instr[14:13];

    assign instr_ready = (state == IDLE);
    assign in_exec     = (state == EXEC);

    assign alu_x = in_exec ? d_reg : '0;
    assign alu_y = in_exec ? (ir[12] ? m_lat : a_reg) : '0;
    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} =
        in_exec ? ir[11:6] : 6'b0;

    assign jump = (ir[2] & alu_ng) | (ir[1] & alu_zr) |
                  (ir[0] & ~alu_ng & ~alu_zr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            d_reg     <= '0;
            pc_out    <= RESET_PC;
            pc_valid  <= 1'b0;
            ir        <= '0;
            m_lat     <= '0;
            addr_lat  <= '0;
            pc_lat    <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            pc_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (instr_valid) begin
                        if (!instr[15]) begin
                            a_reg    <= instr;
                            pc_out   <= pc_out + PC_ONE;
                            pc_valid <= 1'b1;
                        end else begin
                            // address is the A value before this instruction
                            ir       <= instr[12:0];
                            addr_lat <= a_reg[PC_W-1:0];
                            pc_lat   <= pc_out;
                            if (instr[12]) begin
                                state    <= MREAD;
                                mem_rd   <= 1'b1;
                                mem_addr <= a_reg[PC_W-1:0];
                            end else begin
                                state <= EXEC;
                            end
                        end
                    end
                end
                MREAD: begin
                    if (mem_rvalid) begin
                        m_lat  <= mem_rdata;
                        mem_rd <= 1'b0;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (ir[5]) a_reg <= alu_out;
                    if (ir[4]) d_reg <= alu_out;
                    mem_wdata <= alu_out;
                    pc_out    <= jump ? addr_lat : pc_lat + PC_ONE;
                    if (ir[3]) begin
                        state    <= MWRITE;
                        mem_wr   <= 1'b1;
                        mem_addr <= addr_lat;
                    end else begin
                        state    <= IDLE;
                        pc_valid <= 1'b1;
                    end
                end
                MWRITE: begin
                    if (mem_wack) begin
                        mem_wr   <= 1'b0;
                        state    <= IDLE;
                        pc_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_exec_stage.sv
// Bench for hack_exec_stage: bench-side ALU and memory, Hack-level reference
// model, directed scenarios followed by random instruction streams.
module tb_hack_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [14:0] pc_out;
    logic        pc_valid;
    logic [15:0] a_reg, d_reg, alu_x, alu_y;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [15:0] alu_out;
    logic        alu_zr, alu_ng;
    logic [14:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic [15:0] mem_wdata;
    logic        mem_wack = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hack_exec_stage #(.PC_W(15), .RESET_PC(15'd0)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc_out(pc_out), .pc_valid(pc_valid),
        .a_reg(a_reg), .d_reg(d_reg),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
        .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_wack(mem_wack)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bench-side combinational Hack ALU (bit-level control semantics)
    always_comb begin
        logic [15:0] xx, yy, oo;
        xx = alu_zx ? 16'h0 : alu_x;
        xx = alu_nx ? ~xx : xx;
        yy = alu_zy ? 16'h0 : alu_y;
        yy = alu_ny ? ~yy : yy;
        oo = alu_f ? xx + yy : xx & yy;
        oo = alu_no ? ~oo : oo;
        alu_out = oo;
        alu_zr = (oo == 16'h0);
        alu_ng = oo[15];
    end

    logic [15:0] env_mem [0:32767];
    logic [15:0] ref_mem [0:32767];
    int rd_n = 1, wr_n = 1, rd_cnt = 0, wr_cnt = 0, nwrites = 0;
    logic [14:0] last_waddr = '0;
    logic [15:0] last_wdata = '0;

    // Memory responder: rvalid/wack in the rd_n-th / wr_n-th request cycle
    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        mem_wack = 1'b0;
        if (mem_rd) begin
            rd_cnt++;
            if (rd_cnt == rd_n) begin
                mem_rvalid = 1'b1;
                mem_rdata = env_mem[mem_addr];
                rd_cnt = 0;
            end
        end else rd_cnt = 0;
        if (mem_wr) begin
            wr_cnt++;
            if (wr_cnt == wr_n) begin
                mem_wack = 1'b1;
                env_mem[mem_addr] = mem_wdata;
                last_waddr = mem_addr;
                last_wdata = mem_wdata;
                nwrites++;
                wr_cnt = 0;
            end
        end else wr_cnt = 0;
        if (rst_n) chk("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 0);
    end

    // Hack computation table expressed as arithmetic on x=D, y=A/M
    function automatic logic [15:0] alu_ref(input logic [5:0] c,
                                            input logic [15:0] x,
                                            input logic [15:0] y);
        case (c)
            6'b101010: return 16'd0;
            6'b111111: return 16'd1;
            6'b111010: return 16'hFFFF;
            6'b001100: return x;
            6'b110000: return y;
            6'b001101: return ~x;
            6'b110001: return ~y;
            6'b001111: return 16'(-x);
            6'b110011: return 16'(-y);
            6'b011111: return 16'(x + 16'd1);
            6'b110111: return 16'(y + 16'd1);
            6'b001110: return 16'(x - 16'd1);
            6'b110010: return 16'(y - 16'd1);
            6'b000010: return 16'(x + y);
            6'b010011: return 16'(x - y);
            6'b000111: return 16'(y - x);
            6'b000000: return x & y;
            6'b010101: return x | y;
            default:   return 16'hxxxx;
        endcase
    endfunction

    logic [5:0] comps [18] = '{
        6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
        6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
        6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

    logic [15:0] m_a = '0, m_d = '0;
    logic [14:0] m_pc = '0;

    task automatic exec(input logic [15:0] ins, input int rn, input int wn);
        logic [15:0] ya, res, d_old;
        logic [14:0] addr;
        bit is_c, rd, wrm, jmp;
        int lat, n, rph, ex, w0;
        is_c = ins[15];
        rd = is_c & ins[12];
        wrm = is_c & ins[3];
        d_old = m_d;
        addr = m_a[14:0];
        ya = '0;
        res = '0;
        if (!is_c) begin
            m_a = ins;
            m_pc = m_pc + 15'd1;
            lat = 1;
        end else begin
            ya = rd ? ref_mem[addr] : m_a;
            res = alu_ref(ins[11:6], m_d, ya);
            jmp = (ins[2] && res[15]) || (ins[1] && res == 0) ||
                  (ins[0] && !res[15] && res != 0);
            m_pc = jmp ? addr : m_pc + 15'd1;
            if (ins[5]) m_a = res;
            if (ins[4]) m_d = res;
            if (wrm) ref_mem[addr] = res;
            lat = 2 + (rd ? rn : 0) + (wrm ? wn : 0);
        end
        rph = rd ? rn : 0;
        ex = rph + 1;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_issue", {31'd0, instr_ready}, 1);
        rd_n = rn;
        wr_n = wn;
        w0 = nwrites;
        instr = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        n = 1;
        while (n <= 60) begin
            if (is_c && n <= rph) begin
                chk("mread_strobes", {30'd0, mem_rd, mem_wr}, 2);
                chk("mread_addr", {17'd0, mem_addr}, {17'd0, addr});
                chk("mread_alu_idle", {alu_x, alu_y}, 0);
            end else if (is_c && n == ex) begin
                chk("exec_x", {16'd0, alu_x}, {16'd0, d_old});
                chk("exec_y", {16'd0, alu_y}, {16'd0, ya});
                chk("exec_ctl", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny,
                                 alu_f, alu_no}, {26'd0, ins[11:6]});
                chk("exec_result", {16'd0, alu_out}, {16'd0, res});
                chk("exec_no_mem", {30'd0, mem_rd, mem_wr}, 0);
            end else if (wrm && n <= ex + wn) begin
                chk("mwrite_strobes", {30'd0, mem_rd, mem_wr}, 1);
                chk("mwrite_addr", {17'd0, mem_addr}, {17'd0, addr});
                chk("mwrite_data", {16'd0, mem_wdata}, {16'd0, res});
            end
            if (pc_valid) break;
            @(negedge clk);
            n++;
        end
        chk("latency", n, lat);
        chk("pc_out", {17'd0, pc_out}, {17'd0, m_pc});
        chk("a_reg", {16'd0, a_reg}, {16'd0, m_a});
        chk("d_reg", {16'd0, d_reg}, {16'd0, m_d});
        chk("write_count", nwrites - w0, wrm ? 1 : 0);
        if (wrm) begin
            chk("write_addr", {17'd0, last_waddr}, {17'd0, addr});
            chk("write_data", {16'd0, last_wdata}, {16'd0, res});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        for (int i = 0; i < 32768; i++) begin
            v = 16'($urandom);
            env_mem[i] = v;
            ref_mem[i] = v;
        end
        env_mem[5] = 16'd41;
        ref_mem[5] = 16'd41;

        repeat (2) @(negedge clk);
        chk("rst_a", {16'd0, a_reg}, 0);
        chk("rst_d", {16'd0, d_reg}, 0);
        chk("rst_pc", {17'd0, pc_out}, 0);
        chk("rst_flags", {28'd0, pc_valid, instr_ready, mem_rd, mem_wr}, 4);
        chk("rst_mem_bus", {1'b0, mem_addr, mem_wdata}, 0);
        chk("rst_alu_ops", {alu_x, alu_y}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        exec(16'h0005, 1, 1);
        chk("a_is_5", {16'd0, a_reg}, 5);
        exec(16'hEC10, 1, 1);
        chk("d_is_5", {16'd0, d_reg}, 5);
        chk("pc_is_2", {17'd0, pc_out}, 2);
        exec(16'hE308, 1, 3);
        env_mem[5] = 16'd41;
        ref_mem[5] = 16'd41;
        exec(16'hFDE8, 2, 1);
        chk("am_inc_a", {16'd0, a_reg}, 42);
        chk("am_inc_mem", {16'd0, env_mem[5]}, 42);

        exec(16'hEA90, 1, 1);
        exec(16'h0010, 1, 1);
        exec(16'hE301, 1, 1);
        exec(16'hEA87, 1, 1);
        chk("jmp_target", {17'd0, pc_out}, 16);

        exec(16'h7FFF, 1, 1);
        exec(16'hEA87, 1, 1);
        chk("pc_at_top", {17'd0, pc_out}, 32767);
        exec(16'hEA90, 1, 1);
        chk("pc_wrap", {17'd0, pc_out}, 0);

        // back-to-back A-instructions
        instr = 16'h0003;
        instr_valid = 1'b1;
        @(negedge clk);
        chk("b2b_first_valid", {31'd0, pc_valid}, 1);
        chk("b2b_first_a", {16'd0, a_reg}, 3);
        instr = 16'h0007;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("b2b_second_valid", {31'd0, pc_valid}, 1);
        chk("b2b_second_a", {16'd0, a_reg}, 7);
        chk("b2b_pc", {17'd0, pc_out}, {17'd0, 15'(m_pc + 15'd2)});
        m_a = 16'h0007;
        m_pc = m_pc + 15'd2;
        @(negedge clk);

        // reset in the middle of a memory read
        rd_n = 1000;
        instr = 16'hFC10;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_mem_rd", {31'd0, mem_rd}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_rd", {31'd0, mem_rd}, 0);
        chk("mid_rst_regs", {a_reg, d_reg}, 0);
        chk("mid_rst_pc", {17'd0, pc_out}, 0);
        chk("mid_rst_ready", {31'd0, instr_ready}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        m_a = '0;
        m_d = '0;
        m_pc = '0;
        @(negedge clk);

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 1) == 0)
                v = {1'b0, 15'($urandom)};
            else
                v = {1'b1, 2'($urandom), 1'($urandom),
                     comps[$urandom_range(0, 17)], 3'($urandom),
                     3'($urandom)};
            exec(v, $urandom_range(1, 3), $urandom_range(1, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
